// File: rtl/ads131a0x_spi_responder_pkg.sv
// Shared opcodes, response words and decode-state encoding for the ADS131A0x SPI responder.
package ads131a0x_spi_responder_pkg;

    typedef enum logic [1:0] {
        ST_UNREADY  = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_UNLOCKED = 2'd2
    } dev_state_t;

    localparam logic [15:0] CMD_NULL    = 16'h0000;
    localparam logic [15:0] CMD_UNLOCK  = 16'h0655;
    localparam logic [15:0] CMD_LOCK    = 16'h0555;
    localparam logic [15:0] CMD_WAKEUP  = 16'h0033;
    localparam logic [15:0] CMD_STANDBY = 16'h0022;
    localparam logic [15:0] RESP_READY  = 16'hFF04;
    localparam logic [15:0] RESP_STATUS = 16'h2200;

    localparam logic [2:0] OP_RREG = 3'b001;
    localparam logic [2:0] OP_WREG = 3'b010;

    localparam logic [7:0] ID_REG0 = 8'h04;
    localparam logic [7:0] ID_REG1 = 8'h00;

    function automatic logic [15:0] status_word(input logic ovf);
        return RESP_STATUS | {7'd0, ovf, 8'd0};
    endfunction

endpackage

// File: rtl/ads131a0x_spi_responder_edge_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, with registered history for edge pulses.
module ads131a0x_spi_responder_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (reset) sr <= {3{RST_VAL}};
        else       sr <= {sr[1:0], din};
    end

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/ads131a0x_spi_responder.sv
// ADS131A0x device-side SPI model: command decode FSM, frame shifter, DRDY timer and 32x8 register file.
module ads131a0x_spi_responder
    import ads131a0x_spi_responder_pkg::*;
#(
    parameter int WORD_BITS   = 32,
    parameter int NUM_CH      = 4,
    parameter int DRDY_PERIOD = 12500,
    parameter int READY_DLY   = 500
) (
    input  logic                   system_clock,
    input  logic                   reset,
    input  logic                   SPI_SCLK,
    input  logic                   SPI_CS,
    input  logic                   SPI_MOSI,
    input  logic                   SPI_RESET,
    input  logic [NUM_CH*24-1:0]   ch_data,
    output logic                   SPI_MISO,
    output logic                   SPI_DRDY,
    output logic                   awake,
    output logic                   frame_done,
    output logic [15:0]            last_cmd
);

    localparam int FRAME_BITS = (NUM_CH + 1) * WORD_BITS;
    localparam int CNT_W      = $clog2(DRDY_PERIOD + 1);
    localparam int RDY_W      = $clog2(READY_DLY + 1);
    localparam logic [CNT_W-1:0] CONV_RELOAD = CNT_W'(DRDY_PERIOD - 1);
    localparam logic [RDY_W-1:0] RDY_RELOAD  = RDY_W'(READY_DLY - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic rstn_lvl, rstn_rise, rstn_fall;

    ads131a0x_spi_responder_edge_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(system_clock), .reset(reset), .din(SPI_SCLK),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    ads131a0x_spi_responder_edge_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(system_clock), .reset(reset), .din(SPI_CS),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    ads131a0x_spi_responder_edge_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(system_clock), .reset(reset), .din(SPI_MOSI),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
    ads131a0x_spi_responder_edge_sync #(.RST_VAL(1'b1)) u_sync_rstn (
        .clk(system_clock), .reset(reset), .din(SPI_RESET),
        .level(rstn_lvl), .rise(rstn_rise), .fall(rstn_fall));

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall, rstn_rise, rstn_fall};

    // Host-driven SPI_RESET behaves exactly like the system reset for everything past the synchronizers.
    logic dev_rst;
    assign dev_rst = reset | ~rstn_lvl;

    dev_state_t              state_q, state_d;
    logic [15:0]             rx_cmd, resp_q, resp_d, resp_out;
    logic [4:0]              bit_cnt;
    logic                    active, decode_en;
    logic [FRAME_BITS-1:0]   shreg, load_vec;
    logic [NUM_CH*24-1:0]    sample_q;
    logic [7:0]              regs [32];
    logic [7:0]              reg_rd, wr_readback;
    logic [RDY_W-1:0]        ready_cnt;
    logic [CNT_W-1:0]        conv_cnt;
    logic                    ovf_q, drdy_pend, wrap;
    logic                    awake_set, awake_clr, reg_wr, ovf_clr;

    assign decode_en = cs_rise & active & (bit_cnt == 5'd16);
    assign resp_out  = (state_q == ST_UNREADY) ? RESP_READY : resp_q;

    always_comb begin
        load_vec = '0;
        load_vec[FRAME_BITS-1 -: 16] = resp_out;
        for (int n = 0; n < NUM_CH; n++)
            load_vec[FRAME_BITS-1-(n+1)*WORD_BITS -: 24] = sample_q[n*24 +: 24];
    end

    always_ff @(posedge system_clock) begin
        if (dev_rst) begin
            shreg    <= '0;
            SPI_MISO <= 1'b0;
            active   <= 1'b0;
            bit_cnt  <= '0;
            rx_cmd   <= '0;
        end else if (cs_fall) begin
            shreg    <= load_vec;
            SPI_MISO <= 1'b0;
            active   <= 1'b1;
            bit_cnt  <= '0;
            rx_cmd   <= '0;
        end else if (cs_rise) begin
            active <= 1'b0;
        end else if (active) begin
            if (sclk_rise) {SPI_MISO, shreg} <= {shreg, 1'b0};
            if (sclk_fall && bit_cnt < 5'd16) begin
                rx_cmd  <= {rx_cmd[14:0], mosi_lvl};
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    always_comb begin
        case (rx_cmd[12:8])
            5'd0:    reg_rd = ID_REG0;
            5'd1:    reg_rd = ID_REG1;
            default: reg_rd = regs[rx_cmd[12:8]];
        endcase
        wr_readback = (rx_cmd[12:8] >= 5'd2) ? rx_cmd[7:0] : reg_rd;
    end

    always_ff @(posedge system_clock) begin
        if (dev_rst) state_q <= ST_UNREADY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNREADY:  if (ready_cnt == '0) state_d = ST_LOCKED;
            ST_LOCKED:   if (decode_en && rx_cmd == CMD_UNLOCK) state_d = ST_UNLOCKED;
            ST_UNLOCKED: if (decode_en && rx_cmd == CMD_LOCK) state_d = ST_LOCKED;
            default:     state_d = ST_UNREADY;
        endcase
    end

    always_comb begin
        resp_d    = 16'h0000;
        awake_set = 1'b0;
        awake_clr = 1'b0;
        reg_wr    = 1'b0;
        ovf_clr   = 1'b0;
        case (state_q)
            ST_UNREADY: resp_d = RESP_READY;
            ST_LOCKED: begin
                if (rx_cmd == CMD_UNLOCK) begin
                    resp_d = rx_cmd;
                end else if (rx_cmd == CMD_NULL) begin
                    resp_d  = status_word(ovf_q);
                    ovf_clr = 1'b1;
                end
            end
            ST_UNLOCKED: begin
                if (rx_cmd == CMD_NULL) begin
                    resp_d  = status_word(ovf_q);
                    ovf_clr = 1'b1;
                end else if (rx_cmd == CMD_UNLOCK || rx_cmd == CMD_LOCK) begin
                    resp_d = rx_cmd;
                end else if (rx_cmd == CMD_WAKEUP) begin
                    resp_d    = rx_cmd;
                    awake_set = 1'b1;
                end else if (rx_cmd == CMD_STANDBY) begin
                    resp_d    = rx_cmd;
                    awake_clr = 1'b1;
                end else if (rx_cmd[15:13] == OP_RREG) begin
                    resp_d = {OP_RREG, rx_cmd[12:8], reg_rd};
                end else if (rx_cmd[15:13] == OP_WREG) begin
                    resp_d = {OP_RREG, rx_cmd[12:8], wr_readback};
                    reg_wr = 1'b1;
                end
            end
            default: resp_d = 16'h0000;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (dev_rst) begin
            resp_q     <= RESP_READY;
            last_cmd   <= '0;
            frame_done <= 1'b0;
            ready_cnt  <= RDY_RELOAD;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            frame_done <= cs_rise;
            if (state_q == ST_UNREADY && ready_cnt != '0) ready_cnt <= ready_cnt - 1'b1;
            if (decode_en) begin
                resp_q   <= resp_d;
                last_cmd <= rx_cmd;
            end
            if (decode_en && reg_wr && rx_cmd[12:8] >= 5'd2) regs[rx_cmd[12:8]] <= rx_cmd[7:0];
        end
    end

    assign wrap = awake & (conv_cnt == '0);

    // A wrap coinciding with the CS fall is not an overrun: the new sample is kept and DRDY is
    // re-asserted one cycle after the frame has captured the previous one.
    always_ff @(posedge system_clock) begin
        if (dev_rst) begin
            conv_cnt  <= CONV_RELOAD;
            awake     <= 1'b0;
            SPI_DRDY  <= 1'b1;
            drdy_pend <= 1'b0;
            ovf_q     <= 1'b0;
            sample_q  <= '0;
        end else begin
            if (decode_en && awake_clr)  conv_cnt <= CONV_RELOAD;
            else if (wrap)               conv_cnt <= CONV_RELOAD;
            else if (awake)              conv_cnt <= conv_cnt - 1'b1;

            if (decode_en && awake_set)      awake <= 1'b1;
            else if (decode_en && awake_clr) awake <= 1'b0;

            if (decode_en && awake_clr) begin
                SPI_DRDY  <= 1'b1;
                drdy_pend <= 1'b0;
            end else if (cs_fall) begin
                SPI_DRDY  <= 1'b1;
                drdy_pend <= wrap;
            end else if (drdy_pend) begin
                SPI_DRDY  <= 1'b0;
                drdy_pend <= 1'b0;
            end else if (wrap && cs_lvl) begin
                SPI_DRDY <= 1'b0;
            end

            if (wrap && (cs_lvl || cs_fall)) sample_q <= ch_data;

            if (wrap && !cs_lvl && !cs_fall) ovf_q <= 1'b1;
            else if (decode_en && ovf_clr)   ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ads131a0x_spi_responder.sv
// Randomised command-sequence bench for the ADS131A0x responder against a command-level device model.
module tb_ads131a0x_spi_responder;

    localparam int FB   = 160;
    localparam int HALF = 5;

    logic        system_clock = 1'b0;
    logic        reset = 1'b1;
    logic        SPI_SCLK = 1'b0, SPI_CS = 1'b1, SPI_MOSI = 1'b0, SPI_RESET = 1'b1;
    logic [95:0] ch_data = '0;
    logic        SPI_MISO, SPI_DRDY, awake, frame_done;
    logic [15:0] last_cmd;

    ads131a0x_spi_responder dut (
        .system_clock(system_clock), .reset(reset), .SPI_SCLK(SPI_SCLK), .SPI_CS(SPI_CS),
        .SPI_MOSI(SPI_MOSI), .SPI_RESET(SPI_RESET), .ch_data(ch_data), .SPI_MISO(SPI_MISO),
        .SPI_DRDY(SPI_DRDY), .awake(awake), .frame_done(frame_done), .last_cmd(last_cmd));

    always #5 system_clock = ~system_clock;

    int cyc = 0, fd_cnt = 0, n_frames = 0;
    always @(posedge system_clock) begin
        cyc++;
        if (frame_done) fd_cnt++;
    end

    int n_checks = 0, n_errors = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // device model: 0 = not ready, 1 = locked, 2 = unlocked
    int          m_mode;
    logic [15:0] m_pend, m_last;
    logic [7:0]  m_regs [32];
    logic        m_ovf, m_awake;

    task automatic model_reset();
        m_mode = 0; m_pend = 16'hFF04; m_last = 16'h0; m_ovf = 0; m_awake = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a == 0) return 8'h04;
        if (a == 1) return 8'h00;
        return m_regs[a];
    endfunction

    task automatic model_decode(input logic [15:0] cmd);
        int a;
        a = int'(cmd[12:8]);
        m_last = cmd;
        if (m_mode == 0) begin
            m_pend = 16'hFF04;
        end else if (m_mode == 1) begin
            if (cmd == 16'h0655) begin m_pend = cmd; m_mode = 2; end
            else if (cmd == 16'h0000) begin m_pend = m_ovf ? 16'h2300 : 16'h2200; m_ovf = 0; end
            else m_pend = 16'h0000;
        end else begin
            if (cmd == 16'h0000) begin m_pend = m_ovf ? 16'h2300 : 16'h2200; m_ovf = 0; end
            else if (cmd == 16'h0655) m_pend = cmd;
            else if (cmd == 16'h0555) begin m_pend = cmd; m_mode = 1; end
            else if (cmd == 16'h0033) begin m_pend = cmd; m_awake = 1; end
            else if (cmd == 16'h0022) begin m_pend = cmd; m_awake = 0; end
            else if (cmd[15:13] == 3'b001) m_pend = {3'b001, cmd[12:8], m_read(a)};
            else if (cmd[15:13] == 3'b010) begin
                if (a >= 2) m_regs[a] = cmd[7:0];
                m_pend = {3'b001, cmd[12:8], m_read(a)};
            end else m_pend = 16'h0000;
        end
    endtask

    logic [FB-1:0] rx_bits;
    logic          miso_after_rst;

    task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int hold_cyc, input int rst_bit);
        @(negedge system_clock);
        SPI_CS = 1'b0;
        n_frames++;
        rx_bits = '0;
        miso_after_rst = 1'b0;
        repeat (6) @(negedge system_clock);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                SPI_RESET = 1'b0;
                repeat (10) @(negedge system_clock);
                SPI_RESET = 1'b1;
                repeat (6) @(negedge system_clock);
            end
            SPI_SCLK = 1'b1;
            if (i < 16) SPI_MOSI = cmd[15-i];
            else        SPI_MOSI = 1'b0;
            repeat (HALF) @(negedge system_clock);
            if (i < FB) rx_bits[FB-1-i] = SPI_MISO;
            if (rst_bit >= 0 && i > rst_bit) miso_after_rst = miso_after_rst | SPI_MISO;
            SPI_SCLK = 1'b0;
            repeat (HALF) @(negedge system_clock);
        end
        repeat (hold_cyc) @(negedge system_clock);
        SPI_CS = 1'b1;
        SPI_MOSI = 1'b0;
        repeat (10) @(negedge system_clock);
    endtask

    task automatic xfer(input string tag, input logic [15:0] cmd);
        logic [15:0] exp;
        exp = m_pend;
        spi_frame(cmd, 32, 0, -1);
        check(tag, {16'h0, rx_bits[FB-1 -: 16]}, {16'h0, exp});
        model_decode(cmd);
        check({tag, "_awake"}, {31'h0, awake}, {31'h0, m_awake});
        check({tag, "_last_cmd"}, {16'h0, last_cmd}, {16'h0, m_last});
    endtask

    task automatic wait_drdy(output int t);
        logic seen;
        seen = 1'b0;
        t = 0;
        for (int i = 0; i < 13000 && !seen; i++) begin
            @(negedge system_clock);
            if (SPI_DRDY == 1'b0) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        check("drdy_fall_seen", {31'h0, seen}, 32'h1);
    endtask

    function automatic logic [15:0] rand_cmd();
        logic [4:0] a;
        logic [7:0] d;
        a = 5'($urandom_range(0, 31));
        d = 8'($urandom);
        case ($urandom_range(0, 9))
            0:       return 16'h0000;
            1:       return 16'h0655;
            2:       return 16'h0555;
            3:       return 16'h0022;
            4, 5:    return {3'b001, a, d};
            6, 7, 8: return {3'b010, a, d};
            default: return 16'h1000 | {8'h00, d};
        endcase
    endfunction

    initial begin
        #1_200_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t1, t2;
        logic [95:0] pat_a;
        logic [15:0] exp0, c;

        model_reset();
        repeat (5) @(negedge system_clock);
        check("rst_miso", {31'h0, SPI_MISO}, 32'h0);
        check("rst_drdy", {31'h0, SPI_DRDY}, 32'h1);
        check("rst_awake", {31'h0, awake}, 32'h0);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_last_cmd", {16'h0, last_cmd}, 32'h0);
        reset = 1'b0;

        xfer("unready_null", 16'h0000);
        while (cyc < 700) @(negedge system_clock);
        m_mode = 1;
        xfer("ready_report", 16'h0000);
        xfer("locked_status", 16'h0000);
        xfer("locked_rreg", 16'h2000);
        xfer("locked_other", 16'h0655);
        xfer("unlock_echo", 16'h4A5C);
        xfer("wreg_resp", 16'h2A00);
        xfer("rreg_resp", 16'h0000);

        for (int k = 0; k < 24; k++) begin
            c = rand_cmd();
            if ($urandom_range(0, 5) == 0) spi_frame(c, $urandom_range(1, 15), 0, -1);
            else xfer("rand_word0", c);
        end

        xfer("relock_any", 16'h0655);
        check("idle_drdy", {31'h0, SPI_DRDY}, 32'h1);
        xfer("pre_wakeup", 16'h0033);
        pat_a = {24'hABCDEF, 24'($urandom), 24'($urandom), 24'h123456};
        ch_data = pat_a;
        xfer("wakeup_echo", 16'h0000);

        wait_drdy(t1);
        exp0 = m_pend;
        spi_frame(16'h0000, FB, 0, -1);
        check("frame_word0", rx_bits[FB-1 -: 32], {exp0, 16'h0000});
        for (int n = 1; n <= 4; n++)
            check("frame_chan_word", rx_bits[FB-1-n*32 -: 32], {pat_a[(n-1)*24 +: 24], 8'h00});
        model_decode(16'h0000);
        check("drdy_after_frame", {31'h0, SPI_DRDY}, 32'h1);

        ch_data = {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)};
        wait_drdy(t2);
        check("drdy_period", t2 - t1, 32'd12500);

        exp0 = m_pend;
        spi_frame(16'h0000, 32, 13000, -1);
        check("ovf_frame_word0", {16'h0, rx_bits[FB-1 -: 16]}, {16'h0, exp0});
        check("ovf_drdy_held", {31'h0, SPI_DRDY}, 32'h1);
        m_ovf = 1'b1;
        model_decode(16'h0000);
        xfer("ovf_status", 16'h0000);
        xfer("ovf_cleared", 16'h0000);

        xfer("standby_pre", 16'h0022);
        check("standby_drdy", {31'h0, SPI_DRDY}, 32'h1);
        xfer("standby_echo", 16'h0000);

        spi_frame(16'h0555, 10, 0, -1);
        xfer("after_discard", 16'h2A00);
        xfer("discard_kept_unlocked", 16'h0000);

        spi_frame(16'h4A11, 32, 0, 8);
        model_reset();
        check("spi_reset_miso_quiet", {31'h0, miso_after_rst}, 32'h0);
        check("spi_reset_awake", {31'h0, awake}, 32'h0);
        check("spi_reset_drdy", {31'h0, SPI_DRDY}, 32'h1);
        check("spi_reset_last_cmd", {16'h0, last_cmd}, 32'h0);
        spi_frame(16'h0000, 32, 0, -1);
        check("spi_reset_ready_word", {16'h0, rx_bits[FB-1 -: 16]}, 32'h0000FF04);

        repeat (5) @(negedge system_clock);
        check("frame_done_count", fd_cnt, n_frames);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
